// File: rtl/pc_seq_unit.sv
// Registered program counter for the RV32I core: valid/ready fetch request, redirect
// resolution from execute with buffering while a request is held, trap vectoring.
package rv32i_pkg;
    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;
endpackage

module pc_seq_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned           CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_ready,
    input  logic                  ex_valid,
    input  rv32i_base_instr       opcode_e,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] imm_value,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_eq,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    input  logic                  trap_req,
    output logic [ADDR_WIDTH-1:0] link_addr,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  misalign_exc,
    output logic [ADDR_WIDTH-1:0] misalign_addr,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_PEND = 2'd2} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] rtgt_q, rtgt_d, maddr_q, maddr_d;
    logic                  held_q, held_d, rvalid_q, rvalid_d, mexc_q, mexc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  fire_s, taken_s, redir_s, misal_s, count_s;
    logic [ADDR_WIDTH-1:0] calc_tgt_s, final_tgt_s;
    logic                  unused_s;

    // A held request stays raised regardless of stall until the memory accepts it.
    assign fetch_valid     = (state_q != ST_BOOT) && (!stall_i || held_q);
    assign fire_s          = fetch_valid && fetch_ready;
    assign fetch_addr      = pc_q;
    assign link_addr       = ex_pc + PC_STEP;
    assign redirect_valid  = rvalid_q;
    assign redirect_target = rtgt_q;
    assign misalign_exc    = mexc_q;
    assign misalign_addr   = maddr_q;
    assign taken_count     = cnt_q;
    assign unused_s        = alu_result[0];

    // Branch condition evaluation and target computation.
    always_comb begin
        taken_s = 1'b0;
        case (opcode_e)
            JAL, JALR: taken_s = 1'b1;
            BEQ:       taken_s = alu_eq;
            BNE:       taken_s = !alu_eq;
            BLT:       taken_s = alu_lt;
            BGE:       taken_s = !alu_lt;
            BLTU:      taken_s = alu_ltu;
            BGEU:      taken_s = !alu_ltu;
            default:   taken_s = 1'b0;
        endcase
        if (opcode_e == JALR) begin
            calc_tgt_s = {alu_result[ADDR_WIDTH-1:1], 1'b0};
        end else begin
            calc_tgt_s = ex_pc + imm_value[ADDR_WIDTH-1:0];
        end
    end

    // Redirect resolution: trap beats misaligned target beats ordinary taken transfer.
    always_comb begin
        redir_s     = 1'b0;
        misal_s     = 1'b0;
        count_s     = 1'b0;
        final_tgt_s = calc_tgt_s;
        if (ex_valid && trap_req) begin
            redir_s     = 1'b1;
            final_tgt_s = TRAP_VECTOR;
        end else if (ex_valid && taken_s && (calc_tgt_s[1:0] != 2'b00)) begin
            redir_s     = 1'b1;
            misal_s     = 1'b1;
            final_tgt_s = TRAP_VECTOR;
        end else if (ex_valid && taken_s) begin
            redir_s = 1'b1;
            count_s = 1'b1;
        end else begin
            redir_s = 1'b0;
        end
    end

    // Next-state logic for the sequencing FSM and its registered outputs.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        held_d   = fetch_valid && !fetch_ready;
        rvalid_d = redir_s;
        rtgt_d   = redir_s ? final_tgt_s : rtgt_q;
        mexc_d   = misal_s;
        maddr_d  = misal_s ? calc_tgt_s : maddr_q;
        cnt_d    = (count_s && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (redir_s) begin
                    pc_d = final_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_RUN: begin
                if (redir_s && held_q && !fire_s) begin
                    pend_d  = final_tgt_s;
                    state_d = ST_PEND;
                end else if (redir_s) begin
                    pc_d = final_tgt_s;
                end else if (fire_s) begin
                    pc_d = pc_q + PC_STEP;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_PEND: begin
                // Latest redirect wins; one coinciding with acceptance bypasses the buffer.
                if (redir_s && fire_s) begin
                    pc_d    = final_tgt_s;
                    state_d = ST_RUN;
                end else if (redir_s) begin
                    pend_d = final_tgt_s;
                end else if (fire_s) begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_VECTOR;
            pend_q   <= {ADDR_WIDTH{1'b0}};
            held_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rtgt_q   <= {ADDR_WIDTH{1'b0}};
            mexc_q   <= 1'b0;
            maddr_q  <= {ADDR_WIDTH{1'b0}};
            cnt_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            held_q   <= held_d;
            rvalid_q <= rvalid_d;
            rtgt_q   <= rtgt_d;
            mexc_q   <= mexc_d;
            maddr_q  <= maddr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: resolution vectors checked through a scoreboard queue, plus
// hand sequences for held requests, pending redirects, stall, wrap, reset and saturation.
module tb_pc_seq_unit;
    import rv32i_pkg::*;

    logic            clk, rst_n, stall_i, fetch_valid, fetch_ready, ex_valid;
    logic            alu_eq, alu_lt, alu_ltu, trap_req, redirect_valid, misalign_exc;
    logic [31:0]     fetch_addr, ex_pc, imm_value, alu_result, link_addr;
    logic [31:0]     redirect_target, misalign_addr;
    logic [15:0]     taken_count;
    rv32i_base_instr opcode_e;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic ev; rv32i_base_instr op; logic [31:0] pc; logic [31:0] imm; logic [31:0] alu;
        logic eq; logic lt; logic ltu; logic trap;
        logic redir; logic [31:0] tgt; logic mis; logic [31:0] maddr; logic cnt;
    } vec_t;

    typedef struct packed {
        logic redir; logic [31:0] tgt; logic mis; logic [31:0] maddr; logic [15:0] cnt;
    } exp_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    exp_t sb_q[$];
    exp_t e;
    logic [15:0] exp_cnt;

    pc_seq_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0),
        .TRAP_VECTOR(32'h100), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .fetch_valid(fetch_valid),
        .fetch_addr(fetch_addr), .fetch_ready(fetch_ready), .ex_valid(ex_valid),
        .opcode_e(opcode_e), .ex_pc(ex_pc), .imm_value(imm_value), .alu_result(alu_result),
        .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .trap_req(trap_req),
        .link_addr(link_addr), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .misalign_exc(misalign_exc),
        .misalign_addr(misalign_addr), .taken_count(taken_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input rv32i_base_instr op, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] alu, input logic eq,
                         input logic lt, input logic ltu, input logic trap);
        ex_valid = ev; opcode_e = op; ex_pc = pc; imm_value = imm; alu_result = alu;
        alu_eq = eq; alu_lt = lt; alu_ltu = ltu; trap_req = trap;
    endtask

    task automatic idle();
        drive(1'b0, ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jal(input logic [31:0] pc, input logic [31:0] imm);
        drive(1'b1, JAL, pc, imm, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // ev op pc imm alu eq lt ltu trap | redir tgt mis maddr cnt
        vecs[0]  = '{1'b1, BEQ,  32'h40,  32'h20,       32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60,   1'b0, 32'h0,    1'b1};
        vecs[1]  = '{1'b1, BEQ,  32'h40,  32'h20,       32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0};
        vecs[2]  = '{1'b1, BNE,  32'h100, 32'hFFFF_FFF0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF0,   1'b0, 32'h0,    1'b1};
        vecs[3]  = '{1'b1, BLT,  32'h200, 32'h8,        32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h208,  1'b0, 32'h0,    1'b1};
        vecs[4]  = '{1'b1, BGE,  32'h200, 32'h8,        32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0};
        vecs[5]  = '{1'b1, BLTU, 32'h300, 32'h40,       32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h340,  1'b0, 32'h0,    1'b1};
        vecs[6]  = '{1'b1, BGEU, 32'h400, 32'h4,        32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h404,  1'b0, 32'h0,    1'b1};
        vecs[7]  = '{1'b1, JAL,  32'h10,  32'h80,       32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h90,   1'b0, 32'h0,    1'b1};
        vecs[8]  = '{1'b1, JALR, 32'h0,   32'h0,        32'h1003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  1'b1, 32'h1002, 1'b0};
        vecs[9]  = '{1'b1, JALR, 32'h0,   32'h0,        32'h2001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0,    1'b1};
        vecs[10] = '{1'b1, ADD,  32'h40,  32'h20,       32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0};
        vecs[11] = '{1'b1, BNE,  32'h40,  32'h20,       32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100,  1'b0, 32'h0,    1'b0};
        vecs[12] = '{1'b1, BEQ,  32'h40,  32'h22,       32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  1'b1, 32'h62,   1'b0};
        vecs[13] = '{1'b0, JAL,  32'h10,  32'h80,       32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0};
        vecs[14] = '{1'b1, BGE,  32'h500, 32'h10,       32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h510,  1'b0, 32'h0,    1'b1};
        vecs[15] = '{1'b1, BLT,  32'h500, 32'h10,       32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0};
        vecs[16] = '{1'b1, BLTU, 32'h500, 32'h10,       32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0};
        vecs[17] = '{1'b1, BGEU, 32'h500, 32'h10,       32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0};
        vecs[18] = '{1'b1, JALR, 32'h0,   32'h0,        32'h1003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100,  1'b0, 32'h0,    1'b0};
        vecs[19] = '{1'b0, JAL,  32'h0,   32'h0,        32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0};

        rst_n = 1'b0; stall_i = 1'b0; fetch_ready = 1'b1;
        idle();
        #12;
        chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst_fetch_addr", fetch_addr, 32'h0);
        chk("rst_redir_valid", 32'(redirect_valid), 32'h0);
        chk("rst_redir_target", redirect_target, 32'h0);
        chk("rst_misalign_exc", 32'(misalign_exc), 32'h0);
        chk("rst_misalign_addr", misalign_addr, 32'h0);
        chk("rst_taken_count", 32'(taken_count), 32'h0);

        // Release: one BOOT cycle, then sequential fetch 0x0, 0x4, 0x8.
        @(posedge clk); #1; rst_n = 1'b1;
        #2; chk("boot_fetch_valid", 32'(fetch_valid), 32'h0);
        tick(); chk("first_fetch_valid", 32'(fetch_valid), 32'h1);
        chk("first_fetch_addr", fetch_addr, 32'h0);
        tick(); chk("seq_addr_4", fetch_addr, 32'h4);
        tick(); chk("seq_addr_8", fetch_addr, 32'h8);
        chk("seq_taken_count", 32'(taken_count), 32'h0);

        // Resolution vectors; expectations go through the scoreboard queue.
        exp_cnt = 16'h0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ev, vecs[i].op, vecs[i].pc, vecs[i].imm, vecs[i].alu,
                  vecs[i].eq, vecs[i].lt, vecs[i].ltu, vecs[i].trap);
            #2; chk($sformatf("v%0d_link", i), link_addr, vecs[i].pc + 32'h4);
            if (vecs[i].cnt) exp_cnt = exp_cnt + 16'h1;
            e.redir = vecs[i].redir; e.tgt = vecs[i].tgt; e.mis = vecs[i].mis;
            e.maddr = vecs[i].maddr; e.cnt = exp_cnt;
            sb_q.push_back(e);
            tick();
            e = sb_q.pop_front();
            chk($sformatf("v%0d_redir_valid", i), 32'(redirect_valid), 32'(e.redir));
            if (e.redir) begin
                chk($sformatf("v%0d_redir_target", i), redirect_target, e.tgt);
                chk($sformatf("v%0d_fetch_addr", i), fetch_addr, e.tgt);
            end
            chk($sformatf("v%0d_misalign_exc", i), 32'(misalign_exc), 32'(e.mis));
            if (e.mis) chk($sformatf("v%0d_misalign_addr", i), misalign_addr, e.maddr);
            chk($sformatf("v%0d_taken_count", i), 32'(taken_count), 32'(e.cnt));
        end
        idle(); tick();
        chk("idle_redir_valid", 32'(redirect_valid), 32'h0);

        // Held request at 0x20 while two redirects arrive; the latest one wins.
        jal(32'h0, 32'h20); tick();
        chk("pend_setup_addr", fetch_addr, 32'h20);
        idle(); fetch_ready = 1'b0;
        #2; chk("pend_req_valid", 32'(fetch_valid), 32'h1);
        tick(); chk("pend_hold0", fetch_addr, 32'h20);
        jal(32'h10, 32'h80); tick();
        chk("pend_hold1", fetch_addr, 32'h20);
        chk("pend_redir_valid1", 32'(redirect_valid), 32'h1);
        chk("pend_redir_target1", redirect_target, 32'h90);
        idle(); tick();
        chk("pend_hold2", fetch_addr, 32'h20);
        chk("pend_redir_pulse", 32'(redirect_valid), 32'h0);
        jal(32'h100, 32'h100); tick();
        chk("pend_hold3", fetch_addr, 32'h20);
        chk("pend_redir_target2", redirect_target, 32'h200);
        chk("pend_taken_count", 32'(taken_count), 32'd11);
        idle(); fetch_ready = 1'b1; tick();
        chk("pend_latest_wins", fetch_addr, 32'h200);

        // Single pending redirect released by the handshake.
        fetch_ready = 1'b0; tick();
        jal(32'h10, 32'h80); tick();
        chk("pend_single_hold", fetch_addr, 32'h200);
        idle(); fetch_ready = 1'b1; tick();
        chk("pend_single_addr", fetch_addr, 32'h90);
        tick(); chk("pend_after_inc", fetch_addr, 32'h94);

        // Stall does not withdraw a held request; it drops once accepted.
        fetch_ready = 1'b0; tick();
        chk("stall_hold_addr", fetch_addr, 32'h94);
        stall_i = 1'b1;
        #2; chk("stall_held_valid0", 32'(fetch_valid), 32'h1);
        tick(); chk("stall_held_valid1", 32'(fetch_valid), 32'h1);
        chk("stall_held_addr", fetch_addr, 32'h94);
        fetch_ready = 1'b1; tick();
        chk("stall_accept_addr", fetch_addr, 32'h98);
        chk("stall_drop_valid", 32'(fetch_valid), 32'h0);
        tick(); chk("stall_no_advance", fetch_addr, 32'h98);
        stall_i = 1'b0;

        // PC and link address wrap modulo 2^32.
        jal(32'hFFFF_FFF0, 32'hC);
        #2; chk("link_basic", link_addr, 32'hFFFF_FFF4);
        tick(); chk("wrap_setup", fetch_addr, 32'hFFFF_FFFC);
        drive(1'b0, ADD, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2; chk("link_wrap", link_addr, 32'h0);
        tick(); chk("pc_wrap", fetch_addr, 32'h0);
        tick(); chk("pc_after_wrap", fetch_addr, 32'h4);

        // Reset while a redirect is pending discards it.
        fetch_ready = 1'b0; tick();
        jal(32'h10, 32'h300); tick();
        idle();
        #2; rst_n = 1'b0;
        #1; chk("rst_async_addr", fetch_addr, 32'h0);
        chk("rst_async_valid", 32'(fetch_valid), 32'h0);
        chk("rst_async_count", 32'(taken_count), 32'h0);
        chk("rst_async_redir", 32'(redirect_valid), 32'h0);
        fetch_ready = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;
        #2; chk("rst2_boot_valid", 32'(fetch_valid), 32'h0);
        tick(); chk("rst2_first_addr", fetch_addr, 32'h0);
        tick(); chk("rst2_second_addr", fetch_addr, 32'h4);

        // Counter saturation after 65535 taken transfers.
        jal(32'h0, 32'h40);
        for (int k = 0; k < 65534; k++) tick();
        chk("sat_fffe", 32'(taken_count), 32'hFFFE);
        tick(); chk("sat_ffff", 32'(taken_count), 32'hFFFF);
        tick(); chk("sat_hold", 32'(taken_count), 32'hFFFF);
        idle(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Registered program-counter unit for the RV32I core. It replaces the purely combinational next-PC selection with a PC register that drives a valid/ready instruction-fetch request. It resolves control transfers from the execute stage and buffers redirects that arrive while a fetch is stalled. It also detects misaligned jump targets, vectors traps, and counts taken transfers. It sits between the execute stage (branch/ALU results) and the instruction-memory port.

## Interface
- ADDR_WIDTH, 32, PC/address width
- DATA_WIDTH, 32, immediate and ALU result width
- RESET_VECTOR, 0, PC value loaded by reset
- TRAP_VECTOR, 'h100, target for trap_req and misaligned targets
- CNT_WIDTH, 16, taken-transfer counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  suppress new fetch requests
- fetch_valid  out  1  fetch request valid
- fetch_addr  out  ADDR_WIDTH  fetch address (= pc_q)
- fetch_ready  in  1  imem accepts request
- ex_valid  in  1  execute-stage instruction valid
- opcode_e  in  rv32i_base_instr  decoded execute-stage opcode
- ex_pc  in  ADDR_WIDTH  PC of execute-stage instruction
- imm_value  in  DATA_WIDTH  decoded immediate
- alu_result  in  DATA_WIDTH  rs1+imm for JALR
- alu_eq, alu_lt, alu_ltu  in  1 each  comparison flags
- trap_req  in  1  synchronous trap request (valid only with ex_valid)
- link_addr  out  ADDR_WIDTH  ex_pc+4, combinational
- redirect_valid  out  1  registered flush pulse
- redirect_target  out  ADDR_WIDTH  registered redirect address
- misalign_exc  out  1  registered misaligned-target pulse
- misalign_addr  out  ADDR_WIDTH  offending target
- taken_count  out  CNT_WIDTH  saturating taken-transfer count

## Operation
- States: BOOT, RUN, PEND.
  - BOOT is entered on reset. It lasts one cycle with fetch_valid=0, then moves to RUN.
- held_q is set when fetch_valid && !fetch_ready.
- fetch_valid = (state!=BOOT) && (!stall_i || held_q).
  - A request, once raised, stays raised with a stable fetch_addr until accepted, regardless of stall_i.
- Handshake (fetch_valid && fetch_ready) with no redirect: pc_q <= pc_q+4, modulo 2^ADDR_WIDTH (wraps to 0).
- Resolution happens only when ex_valid=1.
  - taken = JAL | JALR | (BEQ&eq) | (BNE&!eq) | (BLT&lt) | (BGE&!lt) | (BLTU&ltu) | (BGEU&!ltu).
- Target:
  - JALR: {alu_result[ADDR_WIDTH-1:1],1'b0}.
  - Otherwise: ex_pc+imm_value truncated to ADDR_WIDTH.
- Priority: trap_req > misaligned > taken.
  - trap_req: target = TRAP_VECTOR, no count.
  - taken && target[1:0]!=0: target = TRAP_VECTOR; misalign_exc=1 and misalign_addr=computed target next cycle; no count.
  - taken, aligned: target as computed; taken_count += 1, saturating at all-ones.
- Redirect application:
  - If held_q=0: pc_q <= target at the edge, overriding any increment from a same-cycle handshake.
  - If held_q=1: store target in pend_q and go to PEND. fetch_addr stays unchanged. On the next handshake, pc_q <= pend_q and state returns to RUN.
  - A new redirect while in PEND overwrites pend_q (latest wins). If it coincides with the handshake, the new target is loaded directly.
- Any redirect (trap, misaligned, taken) sets redirect_valid=1 and redirect_target=final target for exactly one cycle.
- Not-taken branches and ex_valid=0 cause no redirect.

## Timing
- Reset values (asynchronous, immediate):
  - pc_q=RESET_VECTOR, state=BOOT, held_q=0, pend_q=0.
  - fetch_valid=0, redirect_valid=0, redirect_target=0.
  - misalign_exc=0, misalign_addr=0, taken_count=0.
- First request: fetch_valid=1 with fetch_addr=RESET_VECTOR in the second cycle after rst_n rises.
- Resolve-to-redirect latency is 1 cycle. With held_q=0, fetch_addr shows the target in the same cycle that redirect_valid is high.
- With held_q=1, fetch_addr shows the target on the cycle after the handshake. redirect_valid still pulses 1 cycle after resolve.
- Reset asserted mid-PEND discards pend_q. The first fetch after reset is RESET_VECTOR.
- link_addr is combinational with no latency. It wraps modulo 2^ADDR_WIDTH.

## Test plan
- Reset release, fetch_ready=1 constant -> fetch_addr 0x0, 0x4, 0x8 on consecutive cycles; taken_count=0.
- BEQ, ex_pc=0x40, imm=0x20, eq=1, held_q=0 -> next cycle redirect_valid=1, redirect_target=0x60, fetch_addr=0x60, taken_count=1.
- JALR, alu_result=0x1003 -> target 0x1002 is misaligned -> next cycle fetch_addr=0x100, misalign_exc=1, misalign_addr=0x1002, taken_count unchanged.
- fetch_ready=0 holding 0x20, JAL ex_pc=0x10 imm=0x80 -> fetch_addr stays 0x20 until ready; next fetch_addr=0x90. Then a second JAL to 0x200 while pending -> 0x200 replaces 0x90.
- trap_req with taken BNE in the same cycle -> target 0x100, no count increment. stall_i=1 with a held request -> fetch_valid stays 1 until accepted, then drops.
- pc_q=0xFFFFFFFC handshake -> fetch_addr 0x0. 65536 taken JALs with CNT_WIDTH=16 -> taken_count saturates at 0xFFFF.
